// File: rtl/jump_ctrl.sv
// Control-transfer unit: resolves JMP/JZ/JNZ/CALL/RET against a registered Z flag
// and a return-address stack, and drives a one-cycle load/flush pulse to the PC.
module jump_ctrl #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [2:0]                 op,
  input  logic [AW-1:0]              target,
  input  logic [AW-1:0]              pc,
  input  logic                       flag_we,
  input  logic                       flag_z,
  output logic                       load,
  output logic [AW-1:0]              k,
  output logic                       flush,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       stk_ovf,
  output logic                       stk_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic          load_q, load_d;
  logic          flush_q, flush_d;
  logic [AW-1:0] k_q, k_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          z_q, z_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] stack_q [DEPTH];

  logic          accept;
  logic          taken;
  logic          push;
  logic          pop;
  logic [AW-1:0] tgt;
  logic [AW-1:0] ret_addr;
  logic [DW-1:0] depth_m1;
  logic          full;
  logic          empty;

  // The instruction in a flush cycle is wrong-path and must not be accepted.
  assign accept   = instr_valid && !flush_q;
  assign ret_addr = pc + AW'(1);
  assign depth_m1 = depth_q - DW'(1);
  assign full     = (depth_q >= FULL);
  assign empty    = (depth_q == '0);

  always_comb begin
    taken = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    tgt   = target;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (accept) begin
      case (op)
        OP_JMP:  taken = 1'b1;
        OP_JZ:   taken = z_q;
        OP_JNZ:  taken = !z_q;
        OP_CALL: begin
          taken = 1'b1;
          if (!full) push  = 1'b1;
          else       ovf_d = 1'b1;
        end
        OP_RET: begin
          if (!empty) begin
            taken = 1'b1;
            pop   = 1'b1;
            tgt   = stack_q[depth_m1[PW-1:0]];
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_d  = taken;
    flush_d = taken;
    k_d     = taken ? tgt : k_q;
    depth_d = depth_q;
    if (push)     depth_d = depth_q + DW'(1);
    else if (pop) depth_d = depth_m1;
    // Jumps above used the old z_q; the update lands at this same edge.
    z_d     = (flag_we && !flush_q) ? flag_z : z_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 1'b0;
      flush_q <= 1'b0;
      k_q     <= '0;
      depth_q <= '0;
      z_q     <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      flush_q <= flush_d;
      k_q     <= k_d;
      depth_q <= depth_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset; only entries below depth are read.
  always_ff @(posedge clk) begin
    if (push) stack_q[depth_q[PW-1:0]] <= ret_addr;
  end

  assign load    = load_q;
  assign flush   = flush_q;
  assign k       = k_q;
  assign depth   = depth_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule
